pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 45 ++++
 rtl/pipeline_ctrl_redirect_hold.sv | 50 +++++
 rtl/pipeline_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stage bit positions in the
// pause vector, default widths, redirect FSM encoding and the stall encoder.
package pipeline_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;
  localparam int PAUSE_W    = 6;

  // Bit positions inside the pause vector
  localparam int PAUSE_PC  = 0;
  localparam int PAUSE_IF  = 1;
  localparam int PAUSE_ID  = 2;
  localparam int PAUSE_EX  = 3;
  localparam int PAUSE_MEM = 4;
  localparam int PAUSE_WB  = 5;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } redir_state_e;

  // A stall freezes the requesting stage and everything upstream of it;
  // the deepest requester wins. WB is never frozen so the pipe keeps draining.
  function automatic logic [PAUSE_W-1:0] pause_encode(
    input logic if_req,
    input logic id_req,
    input logic ex_req,
    input logic mem_req
  );
    logic [PAUSE_W-1:0] p;
    int upto;
    p    = '0;
    upto = -1;
    if (mem_req)     upto = PAUSE_MEM;
    else if (ex_req) upto = PAUSE_EX;
    else if (id_req) upto = PAUSE_ID;
    else if (if_req) upto = PAUSE_IF;
    for (int i = 0; i < PAUSE_W; i++) begin
      p[i] = (i <= upto);
    end
    p[PAUSE_WB] = 1'b0;
    return p;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_redirect_hold.sv
// Redirect holder: presents a redirect to the PC stage and, when the PC is
// frozen, keeps presenting it from a pending register until the PC can move.
module redirect_hold
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,       // accepted redirect this cycle
  input  logic [ADDR_W-1:0] addr_i,      // selected redirect address
  input  logic              pc_stall_i,  // pause[PC]
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              in_hold_o
);

  redir_state_e      state_q;
  logic [ADDR_W-1:0] pending_q;

  // FSM: a redirect that cannot be taken now is parked until the PC unfreezes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pending_q <= '0;
    end else begin
      if (req_i) begin
        if (pc_stall_i) begin
          state_q   <= ST_HOLD;
          pending_q <= addr_i;
        end else begin
          state_q   <= ST_RUN;
        end
      end else if (state_q == ST_HOLD && !pc_stall_i) begin
        state_q <= ST_RUN;
      end
    end
  end

  // A fresh request always beats the parked address; the top only lets
  // exceptions/ertn through as requests while holding.
  always_comb begin
    in_hold_o = (state_q == ST_HOLD);
    valid_o   = req_i | in_hold_o;
    if (req_i)          pc_o = addr_i;
    else if (in_hold_o) pc_o = pending_q;
    else                pc_o = '0;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall vector generation, flush control, redirect
// source selection and a saturating count of stalled cycles.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               excp_flag,
  input  logic [ADDR_W-1:0]  excp_entry,
  input  logic               ertn_flag,
  input  logic [ADDR_W-1:0]  era,
  output logic [PAUSE_W-1:0] pause,
  output logic               flush_fe,
  output logic               flush_all,
  output logic               redirect_valid,
  output logic [ADDR_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic               trap;
  logic [PAUSE_W-1:0] pause_eff;
  logic [ADDR_W-1:0]  sel_addr;
  logic               branch_acc;
  logic               redir_req;
  logic               hold_valid;
  logic [ADDR_W-1:0]  hold_pc;
  logic               in_hold;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_d;

  // Stall/priority logic: a committed exception or ertn overrides every stall
  always_comb begin
    trap       = excp_flag | ertn_flag;
    pause_eff  = trap ? '0 : pause_encode(stallreq_if, stallreq_id,
                                          stallreq_ex, stallreq_mem);
    if (excp_flag)      sel_addr = excp_entry;
    else if (ertn_flag) sel_addr = era;
    else                sel_addr = branch_target;
    // A branch is dropped if EX is frozen, a trap is present, or a redirect is parked
    branch_acc = branch_flag & ~pause_eff[PAUSE_EX] & ~trap & ~in_hold;
    redir_req  = trap | branch_acc;
  end

  redirect_hold #(
    .ADDR_W(ADDR_W)
  ) u_redirect_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (redir_req),
    .addr_i     (sel_addr),
    .pc_stall_i (pause_eff[PAUSE_PC]),
    .valid_o    (hold_valid),
    .pc_o       (hold_pc),
    .in_hold_o  (in_hold)
  );

  // Next stall count: count frozen cycles, stick at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|pause_eff) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  // Outputs are forced quiet while reset is held, independent of inputs
  always_comb begin
    pause          = rst_n ? pause_eff : '0;
    flush_fe       = rst_n & (branch_acc | in_hold);
    flush_all      = rst_n & trap;
    redirect_valid = rst_n & hold_valid;
    redirect_pc    = rst_n ? hold_pc : '0;
    stall_cnt      = stall_cnt_q;
  end

endmodule
